// File: rtl/cmd_scheduler.sv
// In-order command scheduler: queues SWAP/CLEAN requests in a small FIFO and issues them
// one at a time, following each target engine's BUSY handshake (ack, then completion)
// before moving on to the next queued command.
module cmd_scheduler #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   packet_ready,
    input  logic [7:0]             opcode,
    input  logic [7:0]             BUSY,
    output logic [7:0]             CMD,
    output logic                   q_empty,
    output logic                   q_full,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   active,
    output logic                   overflow,
    output logic                   bad_opcode,
    output logic                   ack_timeout
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitDone} state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] mem_q;  // one bit per entry: 0 = SWAP engine, 1 = CLEAN engine
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic             cur_q, cur_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             overflow_q, overflow_d;
    logic             bad_q, bad_d;
    logic             to_q, to_d;

    logic op_valid, op_clean, push, pop, head_idx, head_busy, cur_busy;

    assign op_valid  = (opcode == 8'h01) || (opcode == 8'h02);
    assign op_clean  = (opcode == 8'h02);
    // A full queue rejects the packet even if the head is popped in the same cycle.
    assign push      = packet_ready && op_valid && (count_q != FullCnt);
    assign head_idx  = mem_q[rd_ptr_q];
    assign head_busy = head_idx ? BUSY[1] : BUSY[0];
    assign cur_busy  = cur_q ? BUSY[1] : BUSY[0];
    assign pop       = (state_q == StIdle) && (count_q != '0) && !head_busy;

    assign overflow_d = packet_ready && op_valid && (count_q == FullCnt);
    assign bad_d      = packet_ready && !op_valid;

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // FIFO storage, pointers, occupancy and rejection pulses.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= op_clean;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
            bad_q      <= bad_d;
        end
    end

    // Scheduler state register plus registered command and timeout pulses.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            cur_q   <= 1'b0;
            cmd_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cur_q   <= cur_d;
            cmd_q   <= cmd_d;
            to_q    <= to_d;
        end
    end

    // Next-state: issue from IDLE, wait for the engine to ack, then to finish.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cur_d   = cur_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StWaitAck;
                    timer_d = '0;
                    cur_d   = head_idx;
                end
            end
            StWaitAck: begin
                if (cur_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TmrLast) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StWaitDone: begin
                if (!cur_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: one-cycle start pulse on issue, one-cycle pulse on ack timeout.
    always_comb begin
        cmd_d = '0;
        to_d  = 1'b0;
        if (pop) begin
            cmd_d = head_idx ? 2'b10 : 2'b01;
        end
        if ((state_q == StWaitAck) && !cur_busy && (timer_q == TmrLast)) begin
            to_d = 1'b1;
        end
    end

    assign CMD         = {6'b0, cmd_q};
    assign q_empty     = (count_q == '0);
    assign q_full      = (count_q == FullCnt);
    assign q_count     = count_q;
    assign active      = (state_q != StIdle);
    assign overflow    = overflow_q;
    assign bad_opcode  = bad_q;
    assign ack_timeout = to_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: directed scenarios plus a randomized run, every cycle compared
// against a queue-based reference model and a simple engine responder.
module tb_cmd_scheduler;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned ACK_TIMEOUT = 16;

    logic                   CLK = 1'b0;
    logic                   rst;
    logic                   packet_ready;
    logic [7:0]             opcode;
    logic [7:0]             BUSY;
    logic [7:0]             CMD;
    logic                   q_empty;
    logic                   q_full;
    logic [$clog2(DEPTH):0] q_count;
    logic                   active;
    logic                   overflow;
    logic                   bad_opcode;
    logic                   ack_timeout;

    cmd_scheduler #(
        .DEPTH      (DEPTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .packet_ready(packet_ready),
        .opcode      (opcode),
        .BUSY        (BUSY),
        .CMD         (CMD),
        .q_empty     (q_empty),
        .q_full      (q_full),
        .q_count     (q_count),
        .active      (active),
        .overflow    (overflow),
        .bad_opcode  (bad_opcode),
        .ack_timeout (ack_timeout)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: pending engine indices in arrival order plus the outstanding command.
    bit   mq[$];
    bit   m_out   = 1'b0;
    bit   m_acked = 1'b0;
    bit   m_cur   = 1'b0;
    int   m_wait  = 0;
    logic [7:0] e_cmd;
    logic e_ovf, e_bad, e_to;

    // Engine responder: raises BUSY for hold_len edges after seeing its start pulse.
    int   left[2];
    bit   no_ack[2];
    int   hold_len   = 3;
    logic [7:0] busy_extra = 8'h00;
    logic [1:0] resp_bits  = 2'b00;

    bit issued[$];
    int cmd_pulses   = 0;
    int last_cmd0    = -1;
    int last_cmd1    = -1;
    int last_to_cyc  = -1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Applies the scheduling rules to the inputs present at this edge.
    task automatic model_edge();
        int cnt;
        bit do_pop;
        bit do_push;
        cnt     = mq.size();
        do_pop  = 1'b0;
        do_push = 1'b0;
        e_cmd   = 8'h00;
        e_ovf   = 1'b0;
        e_bad   = 1'b0;
        e_to    = 1'b0;
        if (rst) begin
            mq.delete();
            m_out   = 1'b0;
            m_acked = 1'b0;
            m_wait  = 0;
            return;
        end
        if (!m_out) begin
            if (cnt > 0 && !BUSY[mq[0]]) begin
                e_cmd[mq[0]] = 1'b1;
                m_cur   = mq[0];
                do_pop  = 1'b1;
                m_out   = 1'b1;
                m_acked = 1'b0;
                m_wait  = 0;
            end
        end else if (!m_acked) begin
            if (BUSY[m_cur]) begin
                m_acked = 1'b1;
            end else begin
                m_wait++;
                if (m_wait == ACK_TIMEOUT) begin
                    e_to  = 1'b1;
                    m_out = 1'b0;
                end
            end
        end else if (!BUSY[m_cur]) begin
            m_out = 1'b0;
        end
        if (packet_ready) begin
            if (opcode != 8'h01 && opcode != 8'h02) e_bad = 1'b1;
            else if (cnt == DEPTH) e_ovf = 1'b1;
            else do_push = 1'b1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(opcode == 8'h02);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        cyc++;
        chk("CMD", CMD, e_cmd);
        chk("q_count", 8'(q_count), 8'(mq.size()));
        chk("q_empty", 8'(q_empty), 8'(mq.size() == 0));
        chk("q_full", 8'(q_full), 8'(mq.size() == DEPTH));
        chk("active", 8'(active), 8'(m_out));
        chk("overflow", 8'(overflow), 8'(e_ovf));
        chk("bad_opcode", 8'(bad_opcode), 8'(e_bad));
        chk("ack_timeout", 8'(ack_timeout), 8'(e_to));
        if (CMD != 8'h00) begin
            cmd_pulses++;
            issued.push_back(CMD[1]);
            if (CMD[0]) last_cmd0 = cyc;
            if (CMD[1]) last_cmd1 = cyc;
        end
        if (ack_timeout) last_to_cyc = cyc;
    endtask

    task automatic set_extra(input logic [7:0] v);
        busy_extra = v;
        BUSY       = busy_extra | {6'b0, resp_bits};
    endtask

    // Advance n edges; packet strobes last one cycle, engines answer their start pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            packet_ready = 1'b0;
            for (int e = 0; e < 2; e++) begin
                if (rst) left[e] = 0;
                else if (CMD[e] && !no_ack[e]) left[e] = hold_len;
                resp_bits[e] = (left[e] > 0);
                if (left[e] > 0) left[e]--;
            end
            BUSY = busy_extra | {6'b0, resp_bits};
        end
    endtask

    task automatic send(input logic [7:0] op);
        packet_ready = 1'b1;
        opcode       = op;
        run(1);
    endtask

    initial begin
        rst          = 1'b1;
        packet_ready = 1'b0;
        opcode       = 8'h00;
        BUSY         = 8'h00;
        left[0] = 0; left[1] = 0;
        no_ack[0] = 1'b0; no_ack[1] = 1'b0;

        // Reset state
        run(2);
        chk("reset_cmd", CMD, 8'h00);
        chk("reset_empty", 8'(q_empty), 8'h01);
        chk("reset_active", 8'(active), 8'h00);
        rst = 1'b0;
        run(1);

        // Single SWAP: pulse two edges after the strobe, one cycle wide, busy for 5 cycles
        hold_len = 5;
        send(8'h01);
        chk("swap_not_yet", CMD, 8'h00);
        run(1);
        chk("swap_latency", CMD, 8'h01);
        run(1);
        chk("swap_width", CMD, 8'h00);
        chk("swap_active", 8'(active), 8'h01);
        run(8);
        chk("swap_done_active", 8'(active), 8'h00);
        chk("swap_done_empty", 8'(q_empty), 8'h01);

        // CLEAN held back while its engine is busy
        set_extra(8'h02);
        send(8'h02);
        for (int i = 0; i < 10; i++) begin
            run(1);
            chk("clean_hold_count", 8'(q_count), 8'h01);
            chk("clean_hold_cmd", CMD, 8'h00);
        end
        set_extra(8'h00);
        run(1);
        chk("clean_release", CMD, 8'h02);
        run(8);

        // Burst of six into a depth-4 queue with both engines busy, then drain in order
        set_extra(8'h03);
        for (int i = 0; i < 6; i++) begin
            send((i % 2 == 0) ? 8'h01 : 8'h02);
            chk("burst_overflow", 8'(overflow), 8'(i >= DEPTH));
        end
        chk("burst_full", 8'(q_full), 8'h01);
        chk("burst_count", 8'(q_count), 8'h04);
        issued.delete();
        hold_len = 3;
        set_extra(8'h00);
        run(40);
        chk("drain_n", 8'(issued.size()), 8'h04);
        for (int i = 0; i < issued.size() && i < 4; i++) begin
            chk("drain_order", 8'(issued[i]), 8'(i % 2));
        end

        // Unsupported opcode
        send(8'h07);
        chk("bad_pulse", 8'(bad_opcode), 8'h01);
        chk("bad_count", 8'(q_count), 8'h00);
        run(1);
        chk("bad_clear", 8'(bad_opcode), 8'h00);
        chk("bad_cmd", CMD, 8'h00);

        // SWAP never acknowledged; the queued CLEAN follows the timeout
        no_ack[0] = 1'b1;
        issued.delete();
        send(8'h01);
        send(8'h02);
        run(ACK_TIMEOUT + 12);
        no_ack[0] = 1'b0;
        chk("to_delay", 8'(last_to_cyc - last_cmd0), 8'(ACK_TIMEOUT));
        chk("to_next_issue", 8'(last_cmd1 - last_to_cyc), 8'h01);
        chk("to_order_n", 8'(issued.size()), 8'h02);
        run(6);

        // Reset in WAIT_DONE with three entries queued
        hold_len = 1000;
        send(8'h01);
        run(3);
        send(8'h02);
        send(8'h01);
        send(8'h02);
        chk("pre_rst_count", 8'(q_count), 8'h03);
        rst = 1'b1;
        run(1);
        chk("rst_count", 8'(q_count), 8'h00);
        chk("rst_active", 8'(active), 8'h00);
        chk("rst_cmd", CMD, 8'h00);
        rst = 1'b0;
        hold_len = 3;
        cmd_pulses = 0;
        run(20);
        chk("rst_no_cmd", 8'(cmd_pulses), 8'h00);

        // Randomized traffic with stray BUSY bits, missed acks and occasional resets
        for (int i = 0; i < 1500; i++) begin
            packet_ready = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0, 1:    opcode = 8'h01;
                2, 3:    opcode = 8'h02;
                default: opcode = 8'($urandom);
            endcase
            hold_len  = $urandom_range(1, 6);
            no_ack[0] = ($urandom_range(0, 9) == 0);
            no_ack[1] = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            set_extra({6'($urandom), ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'b00});
            run(1);
        end
        rst = 1'b0;
        no_ack[0] = 1'b0;
        no_ack[1] = 1'b0;
        set_extra(8'h00);
        run(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
